// File: rtl/bus_xfer_ctrl_pkg.sv
// Shared types and constants for the bus transfer controller.
// Latency: none (declarations only).
// Backpressure: n/a.
//
// Request word is packed {SRC, DST}. A SRC of SEL_NONE is an illegal request;
// the select value SEL_NONE is reserved for "no source driven" while idle.
package bus_xfer_ctrl_pkg;

  localparam int REQ_W = 4;

  localparam logic [1:0] SEL_NONE = 2'b00;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_LOAD  = 2'd2
  } state_t;

  typedef struct packed {
    logic [1:0] src;
    logic [1:0] dst;
  } req_t;

  // One-hot load strobe for a destination register index.
  function automatic logic [3:0] dst_onehot(input logic [1:0] dst);
    return 4'b0001 << dst;
  endfunction

endpackage

// File: rtl/bus_xfer_ctrl_req_fifo.sv
// Synchronous request FIFO with independent read/write pointers and a count.
// Latency: an entry written on edge N becomes poppable on edge N+2 (avail lags one edge).
// Backpressure: full blocks the write; a pop and push together are legal when not full.
//
// Ports:
//   CLK, RST     : clock, synchronous active-high reset (discards contents)
//   push, wr_dat : write request and data; ignored while full
//   pop          : remove head; ignored unless avail
//   rd_dat       : head entry (valid while avail)
//   full         : registered, count == DEPTH
//   avail        : registered, an entry written before the previous edge is present
module req_fifo
  import bus_xfer_ctrl_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int WIDTH = REQ_W
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_dat,
  output logic             full,
  output logic             avail
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             full_q, full_d;
  logic             avail_q, avail_d;
  logic             push_ok;
  logic             pop_ok;

  always_comb begin
    push_ok  = push && !full_q;
    pop_ok   = pop && avail_q;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = wr_dat;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    count_d = count_q + CW'(push_ok) - CW'(pop_ok);
    full_d  = (count_d == CW'(DEPTH));
    // Only entries that were already stored before this edge and survive the
    // pop count as available, so a fresh write is never read in its own cycle.
    avail_d = (count_q != CW'(pop_ok));
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      avail_q  <= 1'b0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      avail_q  <= avail_d;
    end
  end

  assign rd_dat = mem_q[rd_ptr_q];
  assign full   = full_q;
  assign avail  = avail_q;

endmodule

// File: rtl/bus_xfer_ctrl.sv
// Register-transfer controller driving the 3-to-1 bus mux select and load strobes.
// Latency: accept on edge N -> S after N+2 -> LD after N+2+SETUP_CYCLES, one transfer per SETUP_CYCLES+1.
// Backpressure: REQ_READY = !full of the request FIFO; requests wait there while busy.
//
// Parameters: DEPTH (FIFO entries, power of two >= 2), SETUP_CYCLES (1..15).
// Ports:
//   CLK, RST             : clock, synchronous active-high reset (aborts transfer, flushes FIFO)
//   REQ_VALID/REQ_READY  : request handshake; REQ_SRC (1..3), REQ_DST (0..3)
//   S                    : mux select, SEL_NONE only while idle
//   LD                   : one-hot destination load strobe, one cycle per transfer
//   BUSY                 : high in SETUP or LOAD
//   ERR                  : one-cycle pulse when a request with SRC=00 is popped
//   XFER_CNT             : transfer counter, present only with BUS_XFER_COUNT_EN defined
// All outputs are registered.
module bus_xfer_ctrl
  import bus_xfer_ctrl_pkg::*;
#(
  parameter int DEPTH        = 2,
  parameter int SETUP_CYCLES = 1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        REQ_VALID,
  output logic        REQ_READY,
  input  logic [1:0]  REQ_SRC,
  input  logic [1:0]  REQ_DST,
  output logic [1:0]  S,
  output logic [3:0]  LD,
  output logic        BUSY,
  output logic        ERR
`ifdef BUS_XFER_COUNT_EN
  ,
  output logic [15:0] XFER_CNT
`endif
);

  localparam logic [3:0] CNT_INIT = 4'(SETUP_CYCLES - 1);

  state_t     state_q, state_d;
  logic [1:0] s_q, s_d;
  logic [3:0] ld_q, ld_d;
  logic       busy_q, busy_d;
  logic       err_q, err_d;
  logic [3:0] cnt_q, cnt_d;
  logic [1:0] dst_q, dst_d;

  logic             fifo_pop;
  logic             fifo_full;
  logic             fifo_avail;
  logic [REQ_W-1:0] fifo_rd_dat;
  req_t             head;

  req_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (REQ_W)
  ) u_req_fifo (
    .CLK    (CLK),
    .RST    (RST),
    .push   (REQ_VALID),
    .wr_dat ({REQ_SRC, REQ_DST}),
    .pop    (fifo_pop),
    .rd_dat (fifo_rd_dat),
    .full   (fifo_full),
    .avail  (fifo_avail)
  );

  assign head      = req_t'(fifo_rd_dat);
  assign REQ_READY = !fifo_full;

  always_comb begin
    state_d  = state_q;
    s_d      = s_q;
    ld_d     = 4'b0000;
    err_d    = 1'b0;
    cnt_d    = cnt_q;
    dst_d    = dst_q;
    fifo_pop = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (fifo_avail) begin
          fifo_pop = 1'b1;
          if (head.src == SEL_NONE) begin
            // Illegal request is consumed; S stays at SEL_NONE.
            err_d = 1'b1;
          end else begin
            s_d     = head.src;
            dst_d   = head.dst;
            cnt_d   = CNT_INIT;
            state_d = ST_SETUP;
          end
        end
      end

      ST_SETUP: begin
        if (cnt_q == 4'd0) begin
          ld_d    = dst_onehot(dst_q);
          state_d = ST_LOAD;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      ST_LOAD: begin
        // S is still held during the strobe cycle; it only moves when the
        // next transfer starts or when returning to idle.
        if (fifo_avail) begin
          fifo_pop = 1'b1;
          if (head.src == SEL_NONE) begin
            err_d   = 1'b1;
            s_d     = SEL_NONE;
            state_d = ST_IDLE;
          end else begin
            s_d     = head.src;
            dst_d   = head.dst;
            cnt_d   = CNT_INIT;
            state_d = ST_SETUP;
          end
        end else begin
          s_d     = SEL_NONE;
          state_d = ST_IDLE;
        end
      end

      default: begin
        s_d     = SEL_NONE;
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
      s_q     <= SEL_NONE;
      ld_q    <= 4'b0000;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= 4'd0;
      dst_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      ld_q    <= ld_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      dst_q   <= dst_d;
    end
  end

  assign S    = s_q;
  assign LD   = ld_q;
  assign BUSY = busy_q;
  assign ERR  = err_q;

`ifdef BUS_XFER_COUNT_EN
  logic [15:0] xfer_cnt_q, xfer_cnt_d;

  // Counts on the edge that raises LD, so it advances together with the strobe.
  always_comb begin
    xfer_cnt_d = xfer_cnt_q;
    if (ld_d != 4'b0000) begin
      xfer_cnt_d = xfer_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      xfer_cnt_q <= 16'd0;
    end else begin
      xfer_cnt_q <= xfer_cnt_d;
    end
  end

  assign XFER_CNT = xfer_cnt_q;
`endif

endmodule

// File: tb/tb_bus_xfer_ctrl.sv
// Bench for bus_xfer_ctrl: two instances (SETUP_CYCLES 1 and 3) share one stimulus stream.
// Each instance has a transaction-level reference model (queue of stamped requests).
// Outputs are compared every cycle on the falling edge, plus directed timing checks.
`timescale 1ns/1ps
module tb_bus_xfer_ctrl;
  import bus_xfer_ctrl_pkg::*;

  localparam int DEPTH = 2;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       req_valid = 1'b0;
  logic [1:0] req_src = 2'd0;
  logic [1:0] req_dst = 2'd0;

  logic       rdy_o  [2];
  logic [1:0] s_o    [2];
  logic [3:0] ld_o   [2];
  logic       busy_o [2];
  logic       err_o  [2];
`ifdef BUS_XFER_COUNT_EN
  logic [15:0] cnt_o [2];
`endif

  always #5 CLK = ~CLK;

  bus_xfer_ctrl #(.DEPTH(DEPTH), .SETUP_CYCLES(1)) u_dut_s1 (
    .CLK(CLK), .RST(RST), .REQ_VALID(req_valid), .REQ_READY(rdy_o[0]),
    .REQ_SRC(req_src), .REQ_DST(req_dst), .S(s_o[0]), .LD(ld_o[0]),
    .BUSY(busy_o[0]), .ERR(err_o[0])
`ifdef BUS_XFER_COUNT_EN
    , .XFER_CNT(cnt_o[0])
`endif
  );

  bus_xfer_ctrl #(.DEPTH(DEPTH), .SETUP_CYCLES(3)) u_dut_s3 (
    .CLK(CLK), .RST(RST), .REQ_VALID(req_valid), .REQ_READY(rdy_o[1]),
    .REQ_SRC(req_src), .REQ_DST(req_dst), .S(s_o[1]), .LD(ld_o[1]),
    .BUSY(busy_o[1]), .ERR(err_o[1])
`ifdef BUS_XFER_COUNT_EN
    , .XFER_CNT(cnt_o[1])
`endif
  );

  // ---------------- checking ----------------
  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s @cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
  endtask

  // ---------------- reference model ----------------
  // A request is accepted when valid and the model says ready; it can be taken
  // by the controller two edges after acceptance. A transfer taken at edge X
  // drives S from X and raises LD at X+SETUP; the edge after LD is the next
  // decision point.
  typedef struct {
    int         k;
    logic [1:0] src;
    logic [1:0] dst;
    int         t;
  } mreq_t;

  mreq_t      mq[$];
  bit         m_busy [2];
  logic [1:0] m_s    [2];
  logic [3:0] m_ld   [2];
  bit         m_err  [2];
  bit         m_rdy  [2] = '{1'b1, 1'b1};
  int         m_ld_edge [2] = '{-10, -10};
  logic [1:0] m_dst  [2];
  logic [15:0] m_cnt [2] = '{16'd0, 16'd0};

  function automatic int su(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  function automatic int qcount(input int k);
    int n = 0;
    foreach (mq[i]) if (mq[i].k == k) n++;
    return n;
  endfunction

  task automatic model_step(input int k, input logic rst);
    int idx;
    bit decide;
    if (rst) begin
      for (int i = mq.size() - 1; i >= 0; i--) if (mq[i].k == k) mq.delete(i);
      m_busy[k] = 0; m_s[k] = 2'b00; m_ld[k] = 4'b0; m_err[k] = 0;
      m_rdy[k] = 1; m_ld_edge[k] = -10; m_cnt[k] = 16'd0;
      return;
    end
    m_ld[k]  = 4'b0;
    m_err[k] = 0;
    decide = !m_busy[k] || (m_ld_edge[k] == cyc - 1);
    if (decide) begin
      idx = -1;
      for (int i = 0; i < mq.size(); i++) begin
        if (mq[i].k == k) begin idx = i; break; end
      end
      if (idx >= 0 && mq[idx].t + 2 <= cyc) begin
        if (mq[idx].src == 2'b00) begin
          m_err[k] = 1; m_s[k] = 2'b00; m_busy[k] = 0;
        end else begin
          m_s[k] = mq[idx].src; m_dst[k] = mq[idx].dst;
          m_ld_edge[k] = cyc + su(k); m_busy[k] = 1;
        end
        mq.delete(idx);
      end else begin
        m_s[k] = 2'b00; m_busy[k] = 0;
      end
    end else if (cyc == m_ld_edge[k]) begin
      m_ld[k]  = 4'b0001 << m_dst[k];
      m_cnt[k] = m_cnt[k] + 16'd1;
    end
    if (req_valid && m_rdy[k]) begin
      mreq_t r;
      r.k = k; r.src = req_src; r.dst = req_dst; r.t = cyc;
      mq.push_back(r);
    end
    m_rdy[k] = (qcount(k) < DEPTH);
  endtask

  // One clock: model advances at the rising edge, DUT compared at the falling edge.
  task automatic tick();
    @(posedge CLK);
    cyc++;
    model_step(0, RST);
    model_step(1, RST);
    @(negedge CLK);
    for (int k = 0; k < 2; k++) begin
      check($sformatf("S[%0d]", k),     32'(s_o[k]),    32'(m_s[k]));
      check($sformatf("LD[%0d]", k),    32'(ld_o[k]),   32'(m_ld[k]));
      check($sformatf("BUSY[%0d]", k),  32'(busy_o[k]), 32'(m_busy[k]));
      check($sformatf("ERR[%0d]", k),   32'(err_o[k]),  32'(m_err[k]));
      check($sformatf("READY[%0d]", k), 32'(rdy_o[k]),  32'(m_rdy[k]));
      check($sformatf("LD_SEL0[%0d]", k), 32'((ld_o[k] != 4'b0) && (s_o[k] == 2'b00)), 32'd0);
`ifdef BUS_XFER_COUNT_EN
      check($sformatf("XFER_CNT[%0d]", k), 32'(cnt_o[k]), 32'(m_cnt[k]));
`endif
    end
  endtask

  // Holds a request until the SETUP_CYCLES=1 instance accepts it (bounded).
  task automatic send(input logic [1:0] src, input logic [1:0] dst);
    int n = 0;
    req_valid = 1'b1; req_src = src; req_dst = dst;
    while (!m_rdy[0] && n < 50) begin tick(); n++; end
    if (n >= 50) check("send_timeout", 32'd1, 32'd0);
    tick();
    req_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    req_valid = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    int cnt_s3, ld_s3_sel, nld, seen_full;

    // Reset state
    RST = 1'b1;
    tick(); tick();
    RST = 1'b0;
    idle(2);

    // Single request SRC=10 DST=01: accept edge N, S at N+2, LD at N+3, idle at N+4
    send(2'b10, 2'b01);               // edge N
    tick();                           // N+1
    check("lat_S_n1", 32'(s_o[0]), 32'd0);
    tick();                           // N+2
    check("lat_S_n2", 32'(s_o[0]), 32'd2);
    tick();                           // N+3
    check("lat_LD_n3", 32'(ld_o[0]), 32'h2);
    tick();                           // N+4
    check("lat_S_n4", 32'(s_o[0]), 32'd0);
    check("lat_BUSY_n4", 32'(busy_o[0]), 32'd0);
    idle(10);

    // Back-to-back requests with DEPTH=2: READY must drop
    seen_full = 0;
    req_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      req_src = 2'(i % 3 + 1); req_dst = 2'(i);
      tick();
      if (!rdy_o[0]) seen_full = 1;
    end
    req_valid = 1'b0;
    check("ready_drop", 32'(seen_full), 32'd1);
    idle(30);

    // Illegal request then a normal one; SETUP_CYCLES=3 timing on instance 1
    send(2'b00, 2'b11);
    send(2'b11, 2'b00);
    cnt_s3 = 0; ld_s3_sel = 0; nld = 0;
    for (int i = 0; i < 14; i++) begin
      tick();
      if (ld_o[1] != 4'b0) begin
        nld++; ld_s3_sel = 32'(s_o[1]);
        check("s3_ld_val", 32'(ld_o[1]), 32'h1);
      end else if (s_o[1] == 2'b11 && nld == 0) cnt_s3++;
    end
    check("s3_setup_len", 32'(cnt_s3), 32'd3);
    check("s3_s_in_ld", 32'(ld_s3_sel), 32'd3);
    check("s3_ld_count", 32'(nld), 32'd1);
    idle(10);

    // Randomized traffic
    for (int i = 0; i < 500; i++) begin
      req_valid = ($urandom_range(0, 99) < 45);
      req_src   = ($urandom_range(0, 9) == 0) ? 2'b00 : 2'($urandom_range(1, 3));
      req_dst   = 2'($urandom_range(0, 3));
      tick();
    end
    idle(30);

    // Reset during SETUP of instance 1 with two entries queued
    send(2'b01, 2'b10);
    send(2'b10, 2'b11);
    send(2'b11, 2'b01);
    check("pre_rst_busy", 32'(busy_o[1]), 32'd1);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    check("rst_S", 32'(s_o[1]), 32'd0);
    check("rst_LD", 32'(ld_o[1]), 32'd0);
    check("rst_BUSY", 32'(busy_o[1]), 32'd0);
    check("rst_READY", 32'(rdy_o[1]), 32'd1);
    nld = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (ld_o[1] != 4'b0) nld++;
    end
    check("rst_no_ld", 32'(nld), 32'd0);

    // Traffic after reset to confirm normal recovery
    send(2'b01, 2'b11);
    idle(12);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
